// File: rtl/fft_reorder_buffer.sv
// Turns bit-reversed SDF FFT frames into natural order using two register banks (write one, read the other).
// Output valid the cycle after a frame's last write; in_ready falls only while both banks hold unread frames.
module fft_reorder_buffer #(
  parameter int DATA_WIDTH = 10,
  parameter int LOG2N      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [LOG2N-1:0]      out_index,
  output logic                  out_last
);
  localparam int N  = 1 << LOG2N;
  localparam int EW = 2 * DATA_WIDTH;

  logic [EW-1:0]    mem [2][N];
  logic             wr_bank, rd_bank;
  logic [LOG2N-1:0] wr_cnt, rd_cnt;
  logic [1:0]       full, full_next;
  logic             wr_fire, rd_fire, wr_wrap, rd_wrap;
  logic [EW-1:0]    rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = x[LOG2N-1-b];
    return r;
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_wrap   = wr_fire && (&wr_cnt);
  assign rd_wrap   = rd_fire && (&rd_cnt);

  assign rd_word   = mem[rd_bank][rd_cnt];
  assign out_real  = rd_word[EW-1:DATA_WIDTH];
  assign out_imag  = rd_word[DATA_WIDTH-1:0];
  assign out_index = rd_cnt;
  assign out_last  = out_valid && (&rd_cnt);

  // A write completion and a read completion always hit different banks, so both updates apply.
  always_comb begin
    full_next = full;
    if (wr_wrap) full_next[wr_bank] = 1'b1;
    if (rd_wrap) full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + LOG2N'(1);
        if (wr_wrap) wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + LOG2N'(1);
        if (rd_wrap) rd_bank <= !rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < N; e++) mem[b][e] <= '0;
      end
    end else if (wr_fire) begin
      mem[wr_bank][bitrev(wr_cnt)] <= {in_real, in_imag};
    end
  end
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Bench for fft_reorder_buffer: scoreboard of natural-order expectations plus fixed vectors and corner sequences.
module tb_fft_reorder_buffer;
  localparam int DW = 10;
  localparam int LG = 5;
  localparam int NS = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_real = '0, in_imag = '0;
  logic          out_valid, out_ready = 1'b0, out_last;
  logic [DW-1:0] out_real, out_imag;
  logic [LG-1:0] out_index;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic [LG-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    int j;
    int r;
    int i;
    int last;
  } vec_t;

  exp_t          q[$];
  logic [DW-1:0] fr_r[NS], fr_i[NS];
  logic [DW-1:0] cap_r[NS], cap_i[NS];
  logic          cap_last[NS];
  int            checks = 0, errors = 0;
  int            s = 0, wr_k = 0, acc_total = 0, n_out = 0;
  int            ready_mode = 0;
  bit            stream_chk = 0;
  int            stream_gaps = 0, stream_drops = 0;

  fft_reorder_buffer #(.DATA_WIDTH(DW), .LOG2N(LG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] rev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor at the falling edge: records accepts, builds expectations, checks transfers and stalls.
  initial begin
    bit            held;
    logic [DW-1:0] h_r, h_i;
    logic [LG-1:0] h_x;
    exp_t          e;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        wr_k = 0;
        held = 0;
      end else begin
        if (stream_chk && q.size() > 0 && !out_valid) stream_gaps++;
        if (stream_chk && in_valid && !in_ready) stream_drops++;
        if (!out_valid) check("last_while_idle", out_last, 0);
        if (held) begin
          check("stall_valid", out_valid, 1);
          check("stall_real", out_real, h_r);
          check("stall_imag", out_imag, h_i);
          check("stall_index", out_index, h_x);
        end
        held = out_valid && !out_ready;
        h_r = out_real; h_i = out_imag; h_x = out_index;
        if (out_valid && out_ready) begin
          n_out++;
          cap_r[out_index] = out_real;
          cap_i[out_index] = out_imag;
          cap_last[out_index] = out_last;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got index %0d, expected no output", out_index);
          end else begin
            e = q.pop_front();
            check("out_real", out_real, e.r);
            check("out_imag", out_imag, e.i);
            check("out_index", out_index, e.idx);
            check("out_last", out_last, e.last);
          end
        end
        if (in_valid && in_ready) begin
          fr_r[wr_k] = in_real;
          fr_i[wr_k] = in_imag;
          acc_total++;
          wr_k++;
          if (wr_k == NS) begin
            for (int j = 0; j < NS; j++) begin
              e.r = fr_r[rev5(5'(j))];
              e.i = fr_i[rev5(5'(j))];
              e.idx = 5'(j);
              e.last = (j == NS - 1);
              q.push_back(e);
            end
            wr_k = 0;
          end
        end
      end
    end
  end

  // Called aligned to posedge+1; sample s carries real=s, imag=31-s.
  task automatic send_samples(input int n, input int gap_pct);
    bit acc;
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_real  = DW'(s);
      in_imag  = DW'(31 - s);
      acc = 0;
      for (int c = 0; c < 2000 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      check("send_accept", acc, 1);
      if (!acc) break;
      s++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_drained"}, q.size(), 0);
    @(posedge clk); #1;
    check({name, "_idle"}, out_valid, 0);
  endtask

  initial begin
    vec_t tbl[7];
    int   base_acc, base_out, n;
    bit   got_last;

    tbl[0] = '{0, 0, 31, 0};
    tbl[1] = '{1, 16, 15, 0};
    tbl[2] = '{2, 8, 23, 0};
    tbl[3] = '{3, 24, 7, 0};
    tbl[4] = '{16, 1, 30, 0};
    tbl[5] = '{30, 15, 16, 0};
    tbl[6] = '{31, 31, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_imag", out_imag, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    rst_n = 1'b1;

    // Single frame
    ready_mode = 1;
    send_samples(31, 0);
    check("sf_valid_early", out_valid, 0);
    send_samples(1, 0);
    check("sf_latency", out_valid, 1);
    drain("sf");
    for (int v = 0; v < 7; v++) begin
      check($sformatf("tbl_real_j%0d", tbl[v].j), cap_r[tbl[v].j], tbl[v].r);
      check($sformatf("tbl_imag_j%0d", tbl[v].j), cap_i[tbl[v].j], tbl[v].i);
      check($sformatf("tbl_last_j%0d", tbl[v].j), cap_last[tbl[v].j], tbl[v].last);
    end

    // Streaming, 4 frames back to back
    base_out = n_out;
    stream_gaps = 0;
    stream_drops = 0;
    stream_chk = 1;
    send_samples(4 * NS, 0);
    drain("stream");
    stream_chk = 0;
    check("stream_in_ready_drops", stream_drops, 0);
    check("stream_out_gaps", stream_gaps, 0);
    check("stream_count", n_out - base_out, 4 * NS);

    // Backpressure: fill both banks, 65th sample must wait
    ready_mode = 0;
    base_acc = acc_total;
    send_samples(2 * NS, 0);
    fork
      send_samples(NS, 0);
    join_none
    repeat (5) @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_accepts", acc_total - base_acc, 2 * NS);
    ready_mode = 1;
    n = 0;
    got_last = 0;
    for (int c = 0; c < 300 && !got_last; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n++;
        if (out_last) begin
          got_last = 1;
          check("bp_in_ready_at_last", in_ready, 0);
        end
      end
    end
    check("bp_transfers", n, NS);
    @(negedge clk);
    check("bp_in_ready_back", in_ready, 1);
    wait fork;
    drain("bp");

    // Random output stalls with input bubbles
    ready_mode = 2;
    base_out = n_out;
    send_samples(3 * NS, 30);
    drain("rnd");
    check("rnd_count", n_out - base_out, 3 * NS);

    // Reset with frame 0 half read and frame 1 partly written
    ready_mode = 0;
    send_samples(NS, 0);
    ready_mode = 1;
    send_samples(20, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_index", out_index, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_real", out_real, 0);
    rst_n = 1'b1;
    base_out = n_out;
    send_samples(NS, 0);
    drain("post_rst");
    check("post_rst_count", n_out - base_out, NS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_reorder_buffer.md
Name: fft_reorder_buffer

Overview:
Output-side consumer for the SDF FFT pipeline. Accepts one complex sample per cycle in the bit-reversed order produced by the last delay-line/butterfly stage. Emits each frame in natural order through a valid/ready interface. Ping-pong (two-bank) storage lets one frame be written while the previous frame is read, so throughput is sustained at one sample per cycle.

Parameters:
DATA_WIDTH, 10, width of each real/imag component
LOG2N, 5, log2 of frame length; N = 2**LOG2N samples per frame (default 32)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  input sample present
in_ready  out  1  buffer can accept a sample this cycle
in_real  in  DATA_WIDTH  input real part, bit-reversed frame order
in_imag  in  DATA_WIDTH  input imag part
out_valid  out  1  output sample present
out_ready  in  1  downstream accepts the sample
out_real  out  DATA_WIDTH  output real part, natural order
out_imag  out  DATA_WIDTH  output imag part
out_index  out  LOG2N  natural-order bin index of current output sample
out_last  out  1  high with the final sample (index N-1) of a frame

Behaviour:
- Storage: two banks (0/1) of N complex entries each. Entries are registers, like the pipeline delay lines.
- State: wr_bank, rd_bank (1 bit each); wr_cnt, rd_cnt (LOG2N bits each); full[1:0].
- Reset (rst_n=0 at a clock edge):
  - wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=00, all entries 0.
  - Resulting outputs: in_ready=1, out_valid=0, out_real=out_imag=0, out_index=0, out_last=0.
  - Reset mid-frame discards any partial or unread frame.
- Write side:
  - in_ready = !full[wr_bank]. Accept occurs when in_valid & in_ready.
  - On accept: bank[wr_bank][bitrev(wr_cnt)] <= {in_real, in_imag}; wr_cnt increments.
  - If wr_cnt==N-1 on accept: full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
  - in_valid while in_ready=0 is ignored; the source must hold the sample.
  - bitrev() reverses all LOG2N bits of the index.
- Read side:
  - out_valid = full[rd_bank].
  - out_real/out_imag are driven combinationally from bank[rd_bank][rd_cnt].
  - out_index = rd_cnt; out_last = out_valid & (rd_cnt==N-1).
  - Transfer occurs when out_valid & out_ready: rd_cnt increments.
  - On transfer with rd_cnt==N-1: full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0.
  - While out_valid & !out_ready, all outputs hold stable.
  - Outputs other than out_valid are don't-care when out_valid=0. They still show bank[rd_bank][rd_cnt].
- Latency: out_valid rises on the cycle after the edge that accepts sample N-1 of a frame. Minimum in-to-out latency is N cycles from the first accepted sample.
- Full/empty:
  - Both banks full -> in_ready=0 until the read side completes its frame.
  - in_ready re-asserts on the cycle after the out_last transfer.
  - No bank full -> out_valid=0.
- Simultaneous events:
  - Write-completion and read-completion in the same cycle always target different banks: write requires full=0, read requires full=1.
  - Both flag updates apply; each bank flag has exactly one setter and one clearer.
  - A write into bank A and a read from bank B in the same cycle are independent.
- Throughput: with in_valid=1 and out_ready=1 continuously, in_ready stays 1 and out_valid stays 1 after the first frame. One sample per cycle, no bubbles.
- Widths: no arithmetic on data; data passes bit-exact. Counters wrap naturally at N.

Test Plan:
- Single frame, N=32:
  - Stimulus: input k (k=0..31) carries real=k, imag=31-k; out_ready=1.
  - Required: out_valid rises 1 cycle after the 32nd accept. Output j has real=bitrev(j), e.g. j=1 -> 16, j=3 -> 24, j=31 -> 31; imag=31-bitrev(j).
  - Required: out_last only at j=31; then out_valid=0.
- Streaming:
  - Stimulus: 4 back-to-back frames with in_valid=1 every cycle and out_ready=1.
  - Required: in_ready never drops; 128 outputs in natural order; out_valid continuous from cycle 33 on.
- Backpressure:
  - Stimulus: out_ready=0 while 2 frames are written.
  - Required: in_ready=0 after 64 accepts; the 65th sample waits.
  - Required: raise out_ready; in_ready returns the cycle after the out_last transfer (32 transfers later).
- Output stall:
  - Stimulus: toggle out_ready randomly mid-frame.
  - Required: out_real/imag/index are stable whenever out_valid & !out_ready; no sample is duplicated or dropped.
- Input gaps: in_valid with random bubbles -> output sequence identical to the gap-free case.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after 20 accepts of frame 1, with frame 0 half-read.
  - Required: next cycle out_valid=0, in_ready=1, out_index=0.
  - Required: the following clean frame reorders correctly.
